// File: rtl/serial_add_arbiter.sv
// Two-requester adder sharing one 1-bit full adder; operands are summed LSB first.
// Requests are granted round-robin, and the result is held until the consumer takes it.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic             ptr;      // index of the requester served last
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             id_q;
    logic             grant0;
    logic             grant1;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (c & a);
    endfunction

    // On contention the requester not served last wins.
    assign grant0 = req0_valid && (!req1_valid || ptr);
    assign grant1 = req1_valid && !grant0;

    assign req0_ready = !rst && (state == IDLE) && grant0;
    assign req1_ready = !rst && (state == IDLE) && grant1;

    assign s_bit    = fa_sum(a_q[0], b_q[0], carry);
    assign c_next   = fa_carry(a_q[0], b_q[0], carry);
    assign sum_next = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b1;
            carry     <= 1'b0;
            cnt       <= '0;
            id_q      <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q   <= grant1 ? req1_a   : req0_a;
                        b_q   <= grant1 ? req1_b   : req0_b;
                        carry <= grant1 ? req1_cin : req0_cin;
                        id_q  <= grant1;
                        ptr   <= grant1;
                        cnt   <= CW'(WIDTH - 1);
                        sum_q <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    sum_q <= sum_next;
                    carry <= c_next;
                    cnt   <= cnt - 1'b1;
                    // Response registers persist past the DONE handshake.
                    if (cnt == '0) begin
                        rsp_sum   <= sum_next;
                        rsp_cout  <= c_next;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: a timestamp-based reference model is checked every cycle,
// alongside directed scenarios with hand-computed expectations and a randomized phase.
module tb_serial_add_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req0_cin = 1'b0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             req1_cin = 1'b0;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_id;
    logic             busy;

    serial_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: tracks only "busy since accept" and elapsed cycles;
    // the result becomes visible WIDTH+1 cycles after the accept edge.
    bit               m_busy = 0;
    int               m_cnt = 0;
    bit               m_ptr = 1;
    logic [WIDTH-1:0] m_pend_sum = '0;
    logic             m_pend_cout = 0;
    logic             m_pend_id = 0;
    logic [WIDTH-1:0] m_out_sum = '0;
    logic             m_out_cout = 0;
    logic             m_out_id = 0;
    int               m_acc = 0;
    int               m_rsp = 0;
    int               m_drop = 0;

    always @(negedge clk) begin
        bit           g0, g1, ev;
        logic [WIDTH:0] full;
        g0 = req0_valid && (!req1_valid || m_ptr);
        g1 = req1_valid && !g0;
        ev = m_busy && (m_cnt == WIDTH + 1);
        if (ev) begin
            m_out_sum  = m_pend_sum;
            m_out_cout = m_pend_cout;
            m_out_id   = m_pend_id;
        end
        chk("ready0", req0_ready, !rst && !m_busy && g0);
        chk("ready1", req1_ready, !rst && !m_busy && g1);
        chk("rsp_valid", rsp_valid, ev);
        chk("busy", busy, m_busy);
        chk("rsp_sum", rsp_sum, m_out_sum);
        chk("rsp_cout", rsp_cout, m_out_cout);
        chk("rsp_id", rsp_id, m_out_id);
        if (rst) begin
            if (m_busy) m_drop++;
            m_busy = 0; m_cnt = 0; m_ptr = 1;
            m_out_sum = '0; m_out_cout = 0; m_out_id = 0;
        end else if (!m_busy && (g0 || g1)) begin
            full = g1 ? ({1'b0, req1_a} + req1_b + req1_cin) : ({1'b0, req0_a} + req0_b + req0_cin);
            m_pend_sum  = full[WIDTH-1:0];
            m_pend_cout = full[WIDTH];
            m_pend_id   = g1;
            m_ptr  = g1;
            m_busy = 1;
            m_cnt  = 1;
            m_acc++;
        end else if (m_busy) begin
            if (ev && rsp_ready) begin
                m_busy = 0;
                m_rsp++;
            end else if (m_cnt <= WIDTH) begin
                m_cnt++;
            end
        end
    end

    task automatic wait_rsp(output int t);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        t = cyc;
        chk("rsp_seen", ok, 1);
    endtask

    task automatic do_op(input bit who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int t0, t1;
        @(posedge clk); #1;
        if (who) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
        else     begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
        @(negedge clk);
        chk("acc_ready", who ? req1_ready : req0_ready, 1);
        t0 = cyc;
        @(posedge clk); #1;
        // Scramble the requester's inputs while the operation is in flight.
        if (who) begin req1_valid = 0; req1_a = ~a; req1_b = ~b; req1_cin = ~cin; end
        else     begin req0_valid = 0; req0_a = ~a; req0_b = ~b; req0_cin = ~cin; end
        wait_rsp(t1);
        chk("latency", t1 - t0, WIDTH + 1);
        chk("lit_sum", rsp_sum, exp_sum);
        chk("lit_cout", rsp_cout, exp_cout);
        chk("lit_id", rsp_id, who);
    endtask

    initial begin
        int t, tprev, t0, acc_before;
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sum", rsp_sum, 0);
        chk("reset_cout", rsp_cout, 0);
        chk("reset_id", rsp_id, 0);

        do_op(0, 8'hFF, 8'h01, 0, 8'h00, 1);
        do_op(1, 8'h7F, 8'h80, 1, 8'h00, 1);
        do_op(1, 8'h12, 8'h34, 0, 8'h46, 0);

        // Both requesters valid continuously from reset release.
        @(posedge clk); #1;
        rst = 1;
        req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_cin = 0;
        req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h20; req1_cin = 0;
        @(posedge clk); #1 rst = 0;
        tprev = 0;
        for (int i = 0; i < 4; i++) begin
            ok = 0;
            for (int j = 0; j < 30; j++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin ok = 1; break; end
            end
            chk("rr_grant_seen", ok, 1);
            chk("rr_grant_who", req1_ready, i % 2);
            t = cyc;
            if (i > 0) chk("rr_gap", t - tprev, 10);
            tprev = t;
            wait_rsp(t);
            chk("rr_id", rsp_id, i % 2);
            chk("rr_sum", rsp_sum, (i % 2) ? 8'h10 : 8'h30);
            chk("rr_cout", rsp_cout, i % 2);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;

        // Back-pressure: result held for 5 cycles while req1 waits.
        @(posedge clk); #1;
        rsp_ready = 0;
        req0_valid = 1; req0_a = 8'h3C; req0_b = 8'h0F; req0_cin = 1;
        @(negedge clk);
        chk("bp_acc", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_a = 8'h01; req1_b = 8'h02; req1_cin = 0;
        wait_rsp(t);
        chk("bp_sum", rsp_sum, 8'h4C);
        chk("bp_id", rsp_id, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_sum", rsp_sum, 8'h4C);
            chk("bp_hold_ready1", req1_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        chk("bp_hs_valid", rsp_valid, 1);
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_ready1", req1_ready, 1);
        chk("bp_retain_sum", rsp_sum, 8'h4C);
        @(posedge clk); #1 req1_valid = 0;
        wait_rsp(t);
        chk("bp2_sum", rsp_sum, 8'h03);
        chk("bp2_id", rsp_id, 1);

        // Reset pulse in the fourth ADD cycle.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_cin = 0;
        @(negedge clk);
        chk("rst_acc", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_sum", rsp_sum, 0);
        chk("midrst_id", rsp_id, 0);
        chk("midrst_cout", rsp_cout, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        do_op(0, 8'h55, 8'h23, 1, 8'h79, 0);

        // Randomized phase.
        acc_before = m_acc;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            req0_valid = ($urandom % 3) != 0;
            req0_a = WIDTH'($urandom); req0_b = WIDTH'($urandom); req0_cin = 1'($urandom);
            req1_valid = ($urandom % 3) != 0;
            req1_a = WIDTH'($urandom); req1_b = WIDTH'($urandom); req1_cin = 1'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            rst = ($urandom % 400) == 0;
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1; rst = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("rand_ops", (m_acc - acc_before) > 100, 1);
        chk("no_lost_dup", m_rsp + m_drop, m_acc);
        chk("drained", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
